cic_comb_scheduler: RTL and testbench



---
 rtl/cic_comb_scheduler_pkg.sv | 21 ++
 rtl/cic_sub.sv | 15 +
 rtl/cic_comb_scheduler.sv | 157 +++++++++++++++
 tb/tb_cic_comb_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cic_comb_scheduler_pkg.sv
// Shared definitions for the time-multiplexed CIC comb scheduler:
// default width, FSM encoding and channel indices.
package cic_comb_scheduler_pkg;

    localparam int CIC_WIDTH_DEF = 24;

    localparam int CH_L = 0;
    localparam int CH_R = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cic_state_e;

    // Width of a counter able to hold 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cic_sub.sv
// Combinational wrap-around subtractor shared by all comb operations.
module cic_sub
    import cic_comb_scheduler_pkg::*;
#(
    parameter int WIDTH = CIC_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] d_o
);

    // Modulo 2^WIDTH on purpose: CIC output is only correct with wrap.
    assign d_o = a_i - b_i;

endmodule

// File: rtl/cic_comb_scheduler.sv
// Stereo CIC comb section: captures both integrator outputs per frame and runs
// 2*STAGES differentiator ops through one subtractor, left stages first.
module cic_comb_scheduler
    import cic_comb_scheduler_pkg::*;
#(
    parameter int WIDTH  = CIC_WIDTH_DEF,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lr_clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_l,
    input  logic [WIDTH-1:0] in_r,
    output logic [WIDTH-1:0] out_l,
    output logic [WIDTH-1:0] out_r,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int NOPS   = 2 * STAGES;
    localparam int STEP_W = idx_w(NOPS);
    localparam int K_W    = idx_w(STAGES);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NOPS - 1);

    cic_state_e state_q, state_d;

    logic                                 prev_lr_q;
    logic [STEP_W-1:0]                    step_q, step_d;
    logic [1:0][WIDTH-1:0]                work_q, work_d;
    logic [1:0][STAGES-1:0][WIDTH-1:0]    dly_q, dly_d;
    logic [WIDTH-1:0]                     out_l_q, out_l_d;
    logic [WIDTH-1:0]                     out_r_q, out_r_d;
    logic                                 out_valid_q, out_valid_d;
    logic                                 overrun_q, overrun_d;

    logic             lr_edge;
    logic             op_ch;
    logic [K_W-1:0]   op_k;
    logic [WIDTH-1:0] op_a, op_b, op_diff;

    assign lr_edge = lr_clk & ~prev_lr_q;

    // Step -> {channel, stage}: steps 0..STAGES-1 left, the rest right.
    always_comb begin
        op_ch = 1'b0;
        op_k  = '0;
        if (int'(step_q) >= STAGES) begin
            op_ch = 1'b1;
            op_k  = K_W'(int'(step_q) - STAGES);
        end else begin
            op_k  = K_W'(step_q);
        end
    end

    assign op_a = work_q[op_ch];
    assign op_b = dly_q[op_ch][op_k];

    cic_sub #(.WIDTH(WIDTH)) u_sub (
        .a_i (op_a),
        .b_i (op_b),
        .d_o (op_diff)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state; clear wins over everything, including a same-cycle edge
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (lr_edge) state_d = ST_RUN;
                ST_RUN:  if (step_q == LAST_STEP) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy      = (state_q != ST_IDLE);
        out_l     = out_l_q;
        out_r     = out_r_q;
        out_valid = out_valid_q;
        overrun   = overrun_q;
    end

    // Datapath next state
    always_comb begin
        step_d      = step_q;
        work_d      = work_q;
        dly_d       = dly_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        if (clear) begin
            dly_d     = '0;
            step_d    = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lr_edge) begin
                        work_d[CH_L] = in_l;
                        work_d[CH_R] = in_r;
                        step_d       = '0;
                    end
                end
                ST_RUN: begin
                    work_d[op_ch]       = op_diff;
                    dly_d[op_ch][op_k]  = work_q[op_ch];
                    step_d              = step_q + 1'b1;
                    if (lr_edge) overrun_d = 1'b1;
                end
                ST_DONE: begin
                    out_l_d     = work_q[CH_L];
                    out_r_d     = work_q[CH_R];
                    out_valid_d = 1'b1;
                    if (lr_edge) overrun_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_lr_q   <= 1'b0;
            step_q      <= '0;
            work_q      <= '0;
            dly_q       <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            prev_lr_q   <= lr_clk;
            step_q      <= step_d;
            work_q      <= work_d;
            dly_q       <= dly_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_cic_comb_scheduler.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor pops and
// compares whenever out_valid is seen. Unit A: STAGES=3, unit B: STAGES=1.
module tb_cic_comb_scheduler;

    localparam int W = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         lr_a = 1'b0, clr_a = 1'b0;
    logic [W-1:0] inl_a = '0, inr_a = '0;
    logic [W-1:0] outl_a, outr_a;
    logic         ov_a, busy_a, orun_a;

    logic         lr_b = 1'b0, clr_b = 1'b0;
    logic [W-1:0] inl_b = '0, inr_b = '0;
    logic [W-1:0] outl_b, outr_b;
    logic         ov_b, busy_b, orun_b;

    cic_comb_scheduler #(.WIDTH(W), .STAGES(3)) u_dut_a (
        .clk(clk), .rst(rst), .lr_clk(lr_a), .clear(clr_a),
        .in_l(inl_a), .in_r(inr_a), .out_l(outl_a), .out_r(outr_a),
        .out_valid(ov_a), .busy(busy_a), .overrun(orun_a)
    );

    cic_comb_scheduler #(.WIDTH(W), .STAGES(1)) u_dut_b (
        .clk(clk), .rst(rst), .lr_clk(lr_b), .clear(clr_b),
        .in_l(inl_b), .in_r(inr_b), .out_l(outl_b), .out_r(outr_b),
        .out_valid(ov_b), .busy(busy_b), .overrun(orun_b)
    );

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        int           cyc;
    } exp_t;

    exp_t qa[$], qb[$];
    exp_t ea, eb;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_cyc(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: out_valid at cycle %0d expected cycle %0d", name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (ov_a === 1'b1) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_valid: got out_valid=1 expected 0 (cycle %0d, out_l %h)", cyc, outl_a);
            end else begin
                ea = qa.pop_front();
                chk("a_out_l", outl_a, ea.l);
                chk("a_out_r", outr_a, ea.r);
                chk_cyc("a_latency", cyc, ea.cyc);
            end
        end
        if (ov_b === 1'b1) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_valid: got out_valid=1 expected 0 (cycle %0d, out_l %h)", cyc, outl_b);
            end else begin
                eb = qb.pop_front();
                chk("b_out_l", outl_b, eb.l);
                chk("b_out_r", outr_b, eb.r);
                chk_cyc("b_latency", cyc, eb.cyc);
            end
        end
    end

    // One frame every 10 cycles; result due 2*STAGES+2 cycles after the drive negedge.
    task automatic frame_a(input logic [W-1:0] l, input logic [W-1:0] r,
                           input logic [W-1:0] el, input logic [W-1:0] er);
        @(negedge clk);
        lr_a = 1'b1; inl_a = l; inr_a = r;
        qa.push_back('{l: el, r: er, cyc: cyc + 8});
        @(negedge clk);
        lr_a = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_b(input logic [W-1:0] l, input logic [W-1:0] r,
                           input logic [W-1:0] el, input logic [W-1:0] er);
        @(negedge clk);
        lr_b = 1'b1; inl_b = l; inr_b = r;
        qb.push_back('{l: el, r: er, cyc: cyc + 4});
        @(negedge clk);
        lr_b = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_clear_a();
        @(negedge clk); clr_a = 1'b1;
        @(negedge clk); clr_a = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_out_l", outl_a, '0);
        chk("reset_out_r", outr_a, '0);
        chk("reset_out_valid", {23'd0, ov_a}, '0);
        chk("reset_busy", {23'd0, busy_a}, '0);
        chk("reset_overrun", {23'd0, orun_a}, '0);
        chk("reset_b_out_l", outl_b, '0);

        // Impulse response of a 3-stage comb: 1,-3,3,-1,0
        frame_a(24'h000001, 24'h000000, 24'h000001, 24'h000000);
        frame_a(24'h000000, 24'h000000, 24'hFFFFFD, 24'h000000);
        frame_a(24'h000000, 24'h000000, 24'h000003, 24'h000000);
        frame_a(24'h000000, 24'h000000, 24'hFFFFFF, 24'h000000);
        frame_a(24'h000000, 24'h000000, 24'h000000, 24'h000000);

        // Step: left 5, right -2
        frame_a(24'h000005, 24'hFFFFFE, 24'h000005, 24'hFFFFFE);
        frame_a(24'h000005, 24'hFFFFFE, 24'hFFFFF6, 24'h000004);
        frame_a(24'h000005, 24'hFFFFFE, 24'h000005, 24'hFFFFFE);
        frame_a(24'h000005, 24'hFFFFFE, 24'h000000, 24'h000000);

        // Overrun: second edge detected three cycles after the first
        pulse_clear_a();
        chk("clear_overrun_low", {23'd0, orun_a}, '0);
        @(negedge clk);
        lr_a = 1'b1; inl_a = 24'h000001; inr_a = 24'h000000;
        qa.push_back('{l: 24'h000001, r: 24'h000000, cyc: cyc + 8});
        @(negedge clk); lr_a = 1'b0;
        chk("busy_in_run", {23'd0, busy_a}, 24'd1);
        @(negedge clk);
        @(negedge clk); lr_a = 1'b1; inl_a = 24'h000007; inr_a = 24'h000009;
        chk("overrun_before", {23'd0, orun_a}, '0);
        @(negedge clk); lr_a = 1'b0;
        chk("overrun_set", {23'd0, orun_a}, 24'd1);
        repeat (6) @(negedge clk);
        chk("busy_after_overrun", {23'd0, busy_a}, '0);
        repeat (10) @(negedge clk);
        chk("overrun_sticky", {23'd0, orun_a}, 24'd1);
        pulse_clear_a();
        chk("overrun_cleared", {23'd0, orun_a}, '0);
        chk("clear_keeps_out_l", outl_a, 24'h000001);
        frame_a(24'h000001, 24'h000000, 24'h000001, 24'h000000);
        frame_a(24'h000000, 24'h000000, 24'hFFFFFD, 24'h000000);

        // Reset during step 2 of a sequence
        @(negedge clk); lr_a = 1'b1; inl_a = 24'h000001;
        @(negedge clk); lr_a = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("rst_mid_busy", {23'd0, busy_a}, '0);
        chk("rst_mid_out_l", outl_a, '0);
        chk("rst_mid_out_r", outr_a, '0);
        chk("rst_mid_valid", {23'd0, ov_a}, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_mid_idle", {23'd0, busy_a}, '0);
        frame_a(24'h000001, 24'h000000, 24'h000001, 24'h000000);
        frame_a(24'h000000, 24'h000000, 24'hFFFFFD, 24'h000000);

        // clear coincident with an edge: nothing captured
        @(negedge clk); lr_a = 1'b1; clr_a = 1'b1; inl_a = 24'h000009;
        @(negedge clk); lr_a = 1'b0; clr_a = 1'b0;
        chk("clear_edge_busy", {23'd0, busy_a}, '0);
        repeat (10) @(negedge clk);
        chk("clear_edge_idle", {23'd0, busy_a}, '0);
        chk("clear_edge_hold_l", outl_a, 24'hFFFFFD);
        chk("clear_edge_overrun", {23'd0, orun_a}, '0);
        frame_a(24'h000001, 24'h000000, 24'h000001, 24'h000000);
        frame_a(24'h000000, 24'h000000, 24'hFFFFFD, 24'h000000);

        // Wrap with a single stage
        frame_b(24'h7FFFFF, 24'hFFFFFE, 24'h7FFFFF, 24'hFFFFFE);
        frame_b(24'h800000, 24'hFFFFFE, 24'h000001, 24'h000000);
        chk("b_overrun", {23'd0, orun_b}, '0);

        repeat (5) @(negedge clk);
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL a_missing_outputs: got %0d outstanding expected 0", qa.size());
        end
        checks++;
        if (qb.size() != 0) begin
            errors++;
            $display("FAIL b_missing_outputs: got %0d outstanding expected 0", qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
